// File: rtl/nn_config_loader.sv
// ============================================================================
//  Module   : nn_config_loader
//  Purpose  : Parses per-neuron configuration packets from a host word stream
//             (layer, neuron, weight count N, N weights, bias) and drives the
//             shared weight/bias configuration bus watched by every neuron.
//             Packets with an illegal weight count are flagged and drained.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             s_data/s_valid/s_ready - host word stream (ready = cfg_enable & ~rst)
//             cfg_enable          - pause control; low holds all state
//             weightValid/weightValue, biasValid/biasValue - config bus pulses
//             config_layer_num/config_neuron_num - target of current packet
//             busy, pkt_done, pkt_err - packet status
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nn_config_loader #(
  parameter int dataWidth  = 16,
  parameter int maxWeights = 784,
  parameter int cntWidth   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dataWidth-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 cfg_enable,
  output logic                 weightValid,
  output logic [dataWidth-1:0] weightValue,
  output logic                 biasValid,
  output logic [dataWidth-1:0] biasValue,
  output logic [dataWidth-1:0] config_layer_num,
  output logic [dataWidth-1:0] config_neuron_num,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 pkt_err
);

  // One extra bit so an illegal count plus its bias word never wraps.
  localparam int                   REM_W   = cntWidth + 1;
  localparam logic [dataWidth-1:0] MAX_N   = dataWidth'(maxWeights);
  localparam logic [REM_W-1:0]     REM_ONE = REM_W'(1);

  typedef enum logic [2:0] {
    S_LAYER  = 3'd0,
    S_NEURON = 3'd1,
    S_COUNT  = 3'd2,
    S_WEIGHT = 3'd3,
    S_BIAS   = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  state_t               state, state_nx;
  logic [REM_W-1:0]     remaining, remaining_nx;
  logic [dataWidth-1:0] layer_nx, neuron_nx, wval_nx, bval_nx;
  logic                 wv_nx, bv_nx, busy_nx, done_nx, err_nx;
  logic                 accept;

  assign s_ready = cfg_enable & ~rst;
  assign accept  = s_valid & s_ready;

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    layer_nx     = config_layer_num;
    neuron_nx    = config_neuron_num;
    wval_nx      = weightValue;
    bval_nx      = biasValue;
    busy_nx      = busy;
    // Pulse outputs fall back to zero unless this cycle's word raises them.
    wv_nx        = 1'b0;
    bv_nx        = 1'b0;
    done_nx      = 1'b0;
    err_nx       = 1'b0;

    if (accept) begin
      case (state)
        S_LAYER: begin
          layer_nx = s_data;
          busy_nx  = 1'b1;
          state_nx = S_NEURON;
        end
        S_NEURON: begin
          neuron_nx = s_data;
          state_nx  = S_COUNT;
        end
        S_COUNT: begin
          if (s_data == '0) begin
            state_nx = S_BIAS;
          end else if (s_data <= MAX_N) begin
            remaining_nx = REM_W'(s_data);
            state_nx     = S_WEIGHT;
          end else begin
            // Swallow the N weights and the bias of the rejected packet.
            err_nx       = 1'b1;
            remaining_nx = REM_W'(s_data) + REM_ONE;
            state_nx     = S_DRAIN;
          end
        end
        S_WEIGHT: begin
          wv_nx        = 1'b1;
          wval_nx      = s_data;
          remaining_nx = remaining - REM_ONE;
          if (remaining == REM_ONE) begin
            state_nx = S_BIAS;
          end
        end
        S_BIAS: begin
          bv_nx    = 1'b1;
          bval_nx  = s_data;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = S_LAYER;
        end
        S_DRAIN: begin
          remaining_nx = remaining - REM_ONE;
          if (remaining == REM_ONE) begin
            busy_nx  = 1'b0;
            state_nx = S_LAYER;
          end
        end
        default: begin
          state_nx = S_LAYER;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_LAYER;
      remaining         <= '0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      weightValue       <= '0;
      biasValue         <= '0;
      weightValid       <= 1'b0;
      biasValid         <= 1'b0;
      busy              <= 1'b0;
      pkt_done          <= 1'b0;
      pkt_err           <= 1'b0;
    end else begin
      state             <= state_nx;
      remaining         <= remaining_nx;
      config_layer_num  <= layer_nx;
      config_neuron_num <= neuron_nx;
      weightValue       <= wval_nx;
      biasValue         <= bval_nx;
      weightValid       <= wv_nx;
      biasValid         <= bv_nx;
      busy              <= busy_nx;
      pkt_done          <= done_nx;
      pkt_err           <= err_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nn_config_loader.sv
// ============================================================================
//  Module   : tb_nn_config_loader
//  Purpose  : Self-checking bench for nn_config_loader. A packet-position model
//             predicts every registered output; directed packets exercise the
//             normal, bias-only, illegal-count, pause, reset and bubble cases.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nn_config_loader;

  localparam int DW   = 16;
  localparam int MAXW = 784;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          cfg_enable = 1'b1;
  logic          s_ready;
  logic          weightValid, biasValid, busy, pkt_done, pkt_err;
  logic [DW-1:0] weightValue, biasValue, config_layer_num, config_neuron_num;

  nn_config_loader #(.dataWidth(DW), .maxWeights(MAXW), .cntWidth(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_data           (s_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .cfg_enable       (cfg_enable),
    .weightValid      (weightValid),
    .weightValue      (weightValue),
    .biasValid        (biasValid),
    .biasValue        (biasValue),
    .config_layer_num (config_layer_num),
    .config_neuron_num(config_neuron_num),
    .busy             (busy),
    .pkt_done         (pkt_done),
    .pkt_err          (pkt_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Model: each accepted word is classified purely by its position in
  // the packet. Positions 0..2 are header; positions 3..N+2 are weights
  // (or discarded words for an illegal N); position N+3 ends the packet.
  // ------------------------------------------------------------------
  int            pos = 0;
  int            n   = 0;
  logic [DW-1:0] e_layer = '0, e_neuron = '0, e_wval = '0, e_bval = '0;
  logic          e_wv = 0, e_bv = 0, e_busy = 0, e_done = 0, e_err = 0;

  always @(posedge clk) begin
    if (rst) begin
      pos = 0; n = 0;
      e_layer = '0; e_neuron = '0; e_wval = '0; e_bval = '0;
      e_wv = 0; e_bv = 0; e_busy = 0; e_done = 0; e_err = 0;
    end else begin
      e_wv = 0; e_bv = 0; e_done = 0; e_err = 0;
      if (s_valid && cfg_enable) begin
        if (pos == 0) begin
          e_layer = s_data; e_busy = 1;
        end else if (pos == 1) begin
          e_neuron = s_data;
        end else if (pos == 2) begin
          n = int'(s_data);
          if (n > MAXW) e_err = 1;
        end else if (n > MAXW) begin
          // discarded word
        end else if (pos < n + 3) begin
          e_wv = 1; e_wval = s_data;
        end else begin
          e_bv = 1; e_done = 1; e_bval = s_data;
        end
        if (pos >= 3 && pos == n + 3) begin
          pos = 0; e_busy = 0;
        end else begin
          pos++;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("s_ready", s_ready, cfg_enable & ~rst);
    chk("weightValid", weightValid, e_wv);
    chk("weightValue", weightValue, e_wval);
    chk("biasValid", biasValid, e_bv);
    chk("biasValue", biasValue, e_bval);
    chk("layer_num", config_layer_num, e_layer);
    chk("neuron_num", config_neuron_num, e_neuron);
    chk("busy", busy, e_busy);
    chk("pkt_done", pkt_done, e_done);
    chk("pkt_err", pkt_err, e_err);
  end

  // Pulse recorder used by the literal checks.
  logic [DW-1:0] wq[$];
  int            nbias = 0;
  int            nerr  = 0;
  always @(negedge clk) begin
    if (weightValid === 1'b1) wq.push_back(weightValue);
    if (biasValid === 1'b1) nbias++;
    if (pkt_err === 1'b1) nerr++;
  end

  task automatic send(input logic [DW-1:0] w);
    s_data  = w;
    s_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    s_valid = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  int ws, bs;

  initial begin
    rst = 1'b1; cfg_enable = 1'b1; s_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_layer", config_layer_num, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_ready, 0);
    rst = 1'b0;
    idle(1);

    // Basic packet
    send(16'd1); send(16'd2); send(16'd3);
    chk("basic_busy", busy, 1);
    send(16'h0001); chk("basic_w1", weightValue, 16'h0001); chk("basic_wv1", weightValid, 1);
    send(16'h0002); chk("basic_w2", weightValue, 16'h0002);
    send(16'h0003); chk("basic_w3", weightValue, 16'h0003);
    send(16'h0100);
    chk("basic_bv", biasValid, 1); chk("basic_done", pkt_done, 1);
    chk("basic_bias", biasValue, 16'h0100); chk("basic_wv_off", weightValid, 0);
    chk("basic_layer", config_layer_num, 1); chk("basic_neuron", config_neuron_num, 2);
    idle(2);
    chk("basic_wcount", wq.size(), 3);
    chk("basic_q2", wq[2], 16'h0003);

    // Bias only
    ws = wq.size();
    send(16'd2); send(16'd5); send(16'd0);
    send(16'hFFF0);
    chk("bonly_bv", biasValid, 1); chk("bonly_bias", biasValue, 16'hFFF0);
    chk("bonly_busy", busy, 0);
    idle(2);
    chk("bonly_nowv", wq.size(), ws);

    // Illegal count: 785 weights + bias must be swallowed
    ws = wq.size(); bs = nbias;
    send(16'd3); send(16'd4); send(16'd785);
    chk("err_pulse", pkt_err, 1);
    for (int i = 0; i < 786; i++) send(16'(i + 16'h1000));
    chk("err_busy_end", busy, 0);
    idle(2);
    chk("err_nowv", wq.size(), ws);
    chk("err_nobv", nbias, bs);
    chk("err_count", nerr, 1);
    send(16'd5); send(16'd6); send(16'd2);
    send(16'h000A); send(16'h000B); send(16'h000C);
    chk("after_err_done", pkt_done, 1); chk("after_err_bias", biasValue, 16'h000C);
    chk("after_err_layer", config_layer_num, 5);
    idle(2);
    chk("after_err_wq", wq.size(), ws + 2);

    // Pause after 2 of 5 weights
    send(16'd7); send(16'd8); send(16'd5);
    send(16'h0011); send(16'h0012);
    s_data = 16'h0013; s_valid = 1'b1; cfg_enable = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("pause_ready", s_ready, 0);
      chk("pause_nowv", weightValid, 0);
    end
    chk("pause_busy", busy, 1);
    cfg_enable = 1'b1;
    send(16'h0013); chk("pause_w3", weightValue, 16'h0013);
    send(16'h0014); send(16'h0015);
    send(16'h0099);
    chk("pause_done", pkt_done, 1); chk("pause_bias", biasValue, 16'h0099);
    chk("pause_neuron", config_neuron_num, 8);
    idle(2);

    // Reset mid-packet
    send(16'd9); send(16'd1); send(16'd4);
    send(16'h0021); send(16'h0022);
    s_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_wv", weightValid, 0); chk("mrst_wval", weightValue, 0);
    chk("mrst_layer", config_layer_num, 0); chk("mrst_busy", busy, 0);
    rst = 1'b0;
    send(16'h0003);
    chk("mrst_relayer", config_layer_num, 3); chk("mrst_rebusy", busy, 1);
    send(16'd0); send(16'd1); send(16'h0077); send(16'h0088);
    chk("mrst_done", pkt_done, 1); chk("mrst_neuron", config_neuron_num, 0);
    idle(2);

    // Bubbles during weights
    send(16'd4); send(16'd4); send(16'd4);
    for (int i = 0; i < 4; i++) begin
      send(16'(16'h0031 + i));
      chk("bub_wv_on", weightValid, 1);
      chk("bub_wval", weightValue, 16'h0031 + 16'(i));
      idle(1);
      chk("bub_wv_off", weightValid, 0);
    end
    send(16'h0040);
    chk("bub_done", pkt_done, 1);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nn_config_loader.md
# nn_config_loader

Streams pre-trained weights and biases from a host word stream into the neuron array. It parses per-neuron packets and drives the shared configuration bus that every neuron monitors. The bus signals are `weightValid`, `biasValid`, `weightValue`, `biasValue`, `config_layer_num` and `config_neuron_num`. The block sits between the host-facing input FIFO and all layer instances. It is the write side of the neuron weight/bias load interface.

## Interface
Parameters:
- `dataWidth`, 16: stream word width; equals the width of the config value buses.
- `maxWeights`, 784: largest legal weight count per packet.
- `cntWidth`, 16: width of the internal remaining-word counter.

Ports:
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in dataWidth: host stream word.
- `s_valid` in 1: host word valid.
- `s_ready` out 1: loader accepts a word; transfer occurs when `s_valid & s_ready` at a rising edge.
- `cfg_enable` in 1: when low, `s_ready` is forced low (pause); internal state is held.
- `weightValid` out 1: one-cycle pulse per weight word.
- `weightValue` out 16: weight value.
- `biasValid` out 1: one-cycle pulse for the bias word.
- `biasValue` out 16: bias value.
- `config_layer_num` out 16: target layer of the current packet.
- `config_neuron_num` out 16: target neuron of the current packet.
- `busy` out 1: high from header-word acceptance until packet end.
- `pkt_done` out 1: one-cycle pulse, coincident with `biasValid` of a good packet.
- `pkt_err` out 1: one-cycle pulse when an illegal count is accepted.

## Operation
- Packet format, in order:
  - word0 = layer number
  - word1 = neuron number
  - word2 = weight count N
  - N weight words
  - 1 bias word
- `s_ready = cfg_enable & ~rst`. It is combinational and never depends on `s_valid`.
- FSM states:
  - S_LAYER: accept word → latch `config_layer_num`, set `busy`, go to S_NEURON.
  - S_NEURON: accept word → latch `config_neuron_num`, go to S_COUNT.
  - S_COUNT, on acceptance:
    - N == 0 → S_BIAS.
    - 1 ≤ N ≤ maxWeights → load `remaining = N`, go to S_WEIGHT.
    - N > maxWeights → pulse `pkt_err`, load `remaining = N + 1` (cntWidth+1 bits, no wrap), go to S_DRAIN.
  - S_WEIGHT: accept word → `weightValue <= s_data`, pulse `weightValid`, decrement `remaining`; when it reaches 0, go to S_BIAS.
  - S_BIAS: accept word → `biasValue <= s_data`, pulse `biasValid` and `pkt_done`, clear `busy`, go to S_LAYER.
  - S_DRAIN: accept and discard words with no valid pulses, decrement `remaining`; at 0, clear `busy` and go to S_LAYER.
- `config_layer_num` and `config_neuron_num` hold their values from header acceptance until the next packet's header. They are therefore stable for every pulse in the packet.
- `weightValue` and `biasValue` hold their last value between pulses.
- `weightValid` and `biasValid` are never high in the same cycle.
- The loader does not reset neuron write pointers. Reloading a neuron requires a system `rst` first.

## Timing
- All outputs except `s_ready` are registered.
- Reset values: all value/number outputs 0; `weightValid`, `biasValid`, `busy`, `pkt_done`, `pkt_err` all 0; FSM state S_LAYER; `remaining` 0.
- Latency: a word accepted at edge k produces its pulse in the cycle following edge k, lasting exactly one cycle.
- Back-to-back accepted weights produce `weightValid` held high continuously, with `weightValue` changing each cycle.
- Gaps in `s_valid`, or `cfg_enable` low, produce matching gaps in the pulses. No pulse is ever generated without an accepted word.
- `cfg_enable` falling mid-packet: state, counter and latched numbers are frozen; the pulse from the last accepted word still completes.
- `rst` mid-packet: the packet is aborted; the next accepted word is decoded as word0. A partial weight load stays in the neurons.
- Throughput: one word per cycle sustained; a packet of N weights occupies N+4 accepted words.

## Test plan
- Basic packet: layer 1, neuron 2, N=3, weights 0x0001/0x0002/0x0003, bias 0x0100, `s_valid` continuous.
  - Expected: `weightValid` high for 3 consecutive cycles starting one cycle after word 3 is accepted, with values 1, 2, 3.
  - Expected next cycle: `biasValid` = `pkt_done` = 1 with `biasValue` = 0x0100; layer/neuron outputs read 1/2 throughout.
- Bias only: layer 2, neuron 5, N=0, bias 0xFFF0.
  - Expected: no `weightValid`; one `biasValid` with 0xFFF0; `busy` falls the same edge.
- Illegal count: N=785 with maxWeights=784.
  - Expected: `pkt_err` pulses once; the next 786 words are consumed with zero valid pulses.
  - Expected after: a following legal packet loads normally.
- Pause: drop `cfg_enable` after 2 of 5 weights for 10 cycles.
  - Expected: `s_ready` = 0 for those 10 cycles, no pulses; the remaining 3 weights and bias then complete correctly.
- Reset mid-packet: assert `rst` after 2 weights.
  - Expected: all outputs 0 next cycle; the next word (0x0003) appears on `config_layer_num` after acceptance.
- Bubbles: `s_valid` toggling 1/0 during the weights.
  - Expected: `weightValid` toggles identically, delayed by one cycle.
